// File: rtl/edit_pkg.sv
// Shared types and constants for the edit-field selector.
// Optional auto-repeat feature is enabled by defining EDIT_AUTOREPEAT_EN.
package edit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } edit_state_e;

  localparam int unsigned NUM_FIELDS_MIN    = 2;
  localparam int unsigned NUM_FIELDS_MAX    = 16;
  localparam int unsigned REPEAT_DELAY_DEF  = 500;
  localparam int unsigned REPEAT_PERIOD_DEF = 100;

endpackage

// File: rtl/edit_field_sel_key_edge_det.sv
// One-flop rising-edge detector for a debounced, clock-synchronous key level.
module key_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_edge,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= i_key;
  end

  assign o_q    = r_q;
  assign o_edge = i_key & ~r_q;

endmodule

// File: rtl/edit_field_sel.sv
// Edit-field selector: mode key cycles the edited field, up key pulses that field's counter.
// Define EDIT_AUTOREPEAT_EN to add hold-to-repeat (HOLD/REPEAT sub-states of EDIT).
module edit_field_sel
  import edit_pkg::*;
#(
  parameter int NUM_FIELDS    = 6,
  parameter int REPEAT_DELAY  = int'(REPEAT_DELAY_DEF),
  parameter int REPEAT_PERIOD = int'(REPEAT_PERIOD_DEF),
  localparam int IDX_W        = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  on_off,
  input  logic                  mode_key,
  input  logic                  up_key,
  output logic [NUM_FIELDS-1:0] up,
  output logic [NUM_FIELDS-1:0] select,
  output logic [IDX_W-1:0]      field_idx,
  output edit_state_e           dbg_state
);

  edit_state_e           r_state, w_state_nx;
  logic [IDX_W-1:0]      r_idx, w_idx_nx;
  logic [NUM_FIELDS-1:0] r_select, w_select_nx;
  logic [NUM_FIELDS-1:0] r_up, w_up_nx;
  logic                  w_mode_edge, w_up_edge;
  logic                  w_mode_q, w_up_q;

  key_edge_det u_mode_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key  (mode_key),
    .o_edge (w_mode_edge),
    .o_q    (w_mode_q)
  );

  key_edge_det u_up_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_key  (up_key),
    .o_edge (w_up_edge),
    .o_q    (w_up_q)
  );

`ifdef EDIT_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] w_cnt_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_cnt_nx;
  end

  assign w_cnt_target = (r_state == HOLD) ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_select_nx = r_select;
    w_up_nx     = '0;
`ifdef EDIT_AUTOREPEAT_EN
    w_cnt_nx    = r_cnt;
`endif
    if (!on_off) begin
      w_state_nx  = IDLE;
      w_idx_nx    = '0;
      w_select_nx = '0;
`ifdef EDIT_AUTOREPEAT_EN
      w_cnt_nx    = '0;
`endif
    end else if (r_state == IDLE) begin
      w_state_nx  = EDIT;
      w_idx_nx    = '0;
      w_select_nx = NUM_FIELDS'(1);
    end else begin
      // The pulse targets the field selected before any same-edge mode advance.
      if (w_up_edge) w_up_nx = r_select;
      if (w_mode_edge) begin
        w_idx_nx    = (r_idx == IDX_W'(NUM_FIELDS - 1)) ? '0 : r_idx + 1'b1;
        w_select_nx = NUM_FIELDS'(1) << w_idx_nx;
      end
`ifdef EDIT_AUTOREPEAT_EN
      case (r_state)
        EDIT: begin
          if (w_up_edge) begin
            w_state_nx = HOLD;
            w_cnt_nx   = CNT_W'(1);
          end
        end
        HOLD, REPEAT: begin
          // Falling back to EDIT while the key is held suppresses repeat until release.
          if (!up_key || w_mode_edge) begin
            w_state_nx = EDIT;
            w_cnt_nx   = '0;
          end else if (r_cnt == w_cnt_target) begin
            w_up_nx    = r_select;
            w_state_nx = REPEAT;
            w_cnt_nx   = CNT_W'(1);
          end else begin
            w_cnt_nx   = r_cnt + 1'b1;
          end
        end
        default: w_state_nx = IDLE;
      endcase
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_select <= '0;
      r_up     <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_select <= w_select_nx;
      r_up     <= w_up_nx;
    end
  end

  assign up        = r_up;
  assign select    = r_select;
  assign field_idx = r_idx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_edit_field_sel.sv
// Scoreboard bench for edit_field_sel; builds with or without EDIT_AUTOREPEAT_EN.
module tb_edit_field_sel;
  import edit_pkg::*;

  localparam int N  = 6;
  localparam int IW = 3;
`ifdef EDIT_AUTOREPEAT_EN
  localparam int RD = 10;
  localparam int RP = 4;
  localparam bit AR = 1'b1;
`else
  localparam int RD = 500;
  localparam int RP = 100;
  localparam bit AR = 1'b0;
`endif
  localparam int W = 2 * N + IW;

  logic          clk, rst_n, on_off, mode_key, up_key;
  logic [N-1:0]  up, select;
  logic [IW-1:0] field_idx;
  edit_state_e   dbg_state;

  edit_field_sel #(
    .NUM_FIELDS    (N),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .on_off    (on_off),
    .mode_key  (mode_key),
    .up_key    (up_key),
    .up        (up),
    .select    (select),
    .field_idx (field_idx),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which field is edited, and how long the accepted press has lasted.
  bit m_edit, m_prev_up, m_prev_mode, m_press;
  int m_idx, m_held;

  always @(posedge clk) begin : ref_model
    bit ur, mr, pulse;
    logic [N-1:0] e_up, e_sel;
    e_up = '0;
    if (!rst_n) begin
      m_edit = 0; m_idx = 0; m_prev_up = 0; m_prev_mode = 0; m_press = 0; m_held = 0;
    end else begin
      ur = up_key && !m_prev_up;
      mr = mode_key && !m_prev_mode;
      if (!on_off) begin
        m_edit = 0; m_idx = 0; m_press = 0;
      end else if (!m_edit) begin
        m_edit = 1; m_idx = 0; m_press = 0;
      end else begin
        pulse = 0;
        if (ur) begin
          pulse = 1; m_press = 1; m_held = 0;
        end else if (m_press && up_key) begin
          m_held++;
          if (AR && !mr && m_held >= RD && ((m_held - RD) % RP) == 0) pulse = 1;
        end
        if (!up_key || (mr && !ur)) m_press = 0;
        if (pulse) e_up = N'(1) << m_idx;
        if (mr) m_idx = (m_idx + 1) % N;
      end
      m_prev_up   = up_key;
      m_prev_mode = mode_key;
    end
    e_sel = m_edit ? (N'(1) << m_idx) : '0;
    exp_q.push_back({e_up, e_sel, IW'(m_idx)});
  end

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("outputs{up,select,idx}", 32'({up, select, field_idx}), 32'(e));
      check("up_onehot0", 32'($onehot0(up)), 32'(1));
      check("up_implies_select", 32'((up == '0) || (select != '0)), 32'(1));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    mode_key = 1'b1; tick(1); mode_key = 1'b0; tick(2);
  endtask

  initial begin
    rst_n = 1'b0; on_off = 1'b0; mode_key = 1'b0; up_key = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    on_off = 1'b1;
    tick(2);
    repeat (6) press_mode();
    press_mode(); press_mode();
    up_key = 1'b1; tick(50); up_key = 1'b0; tick(3);
    repeat (3) press_mode();
    mode_key = 1'b1; up_key = 1'b1; tick(1);
    mode_key = 1'b0; up_key = 1'b0; tick(3);
    // key held while edit mode is entered, then edit dropped mid-hold
    on_off = 1'b0; tick(2);
    up_key = 1'b1; tick(2);
    on_off = 1'b1; tick(5);
    on_off = 1'b0; tick(2);
    up_key = 1'b0; tick(2);
    on_off = 1'b1; tick(2);
    up_key = 1'b1; tick(30); up_key = 1'b0; tick(10);
    up_key = 1'b1; tick(12); press_mode(); tick(20); up_key = 1'b0; tick(3);
    // asynchronous reset in the middle of a press
    up_key = 1'b1; tick(3);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'({up, select, field_idx}), 32'(0));
    tick(2);
    rst_n = 1'b1;
    tick(5);
    up_key = 1'b0; tick(2);
    up_key = 1'b1; tick(2); up_key = 1'b0; tick(2);
    // randomized key activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) on_off = ~on_off;
      if ($urandom_range(0, 7) == 0) mode_key = ~mode_key;
      if ($urandom_range(0, 15) == 0) up_key = ~up_key;
      tick(1);
    end
    on_off = 1'b1; mode_key = 1'b0; up_key = 1'b0;
    tick(4);
    check("scoreboard_drained", 32'(exp_q.size() <= 1), 32'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
